jesd204b_rx_link_fsm: RTL
=========================

// Module: jesd204b_rx_link_fsm
// PURPOSE
//  JESD204B subclass-1 receive link controller for one lane. Sequences the GT wizard reset, enables comma
//  alignment, runs code-group sync (CGS) and ILAS detection, drives NSYNC aligned to LMFC, and gates
//  received user data. Sits between the GTY wizard and user/AXIS logic inside the RX core, on the dclk.
// PARAMETERS
//  USERDATA_WIDTH  32  GT user data width; fixed 4 bytes/clk, byte0 = [7:0] is first in time
//  FRAME_SIZE      1   F, octets per frame
//  FMLC_NUM        32  K, frames per multiframe; F*K must be a multiple of 4, LMFC_PERIOD = F*K/4 clks
//  LMFC_CNT_WIDTH  8   LMFC counter width; LMFC_PERIOD <= 2**LMFC_CNT_WIDTH
//  RESET_HOLD      16  clks o_gt_reset_all is held high
//  GT_TIMEOUT      65535  clks allowed in WAIT_GT or ILAS before retry
//  CGS_K_CNT       4   consecutive all-/K/ words required to pass CGS
// PORTS
//  i_dclk               in   1   link clock (GT rxusrclk2 domain); all logic on rising edge
//  i_rst_n              in   1   asynchronous active-low reset
//  i_sysref             in   1   SYSREF, already synchronous to i_dclk
//  i_gtpowergood        in   1   GT power good
//  i_gt_reset_rx_done   in   1   GT wizard RX reset done
//  i_rxbyteisaligned    in   1   GT comma byte-alignment status
//  i_rx_data            in   32  GT user data, 8b10b decoded
//  i_rx_charisk         in   4   per-byte K-character flag (rxctrl0[3:0])
//  o_gt_reset_all       out  1   GT wizard reset_all
//  o_rxpcommaalignen    out  1   P comma align enable
//  o_rxmcommaalignen    out  1   M comma align enable (always equal to P)
//  o_nsync              out  1   SYNC~, active low: 0 = request CGS
//  o_lmfc_pulse         out  1   one-clk pulse at LMFC counter == 0
//  o_data               out  32  registered user data
//  o_data_valid         out  1   o_data is payload
//  o_link_up            out  1   high only in DATA state
//  o_state              out  3   0 RESET_GT,1 WAIT_GT,2 CGS,3 ILAS,4 DATA
// BEHAVIOUR
//  Reset (i_rst_n=0, async): state=RESET_GT, hold counter 0, lmfc counter 0; all outputs 0 (o_nsync=0).
//  /K/ word: i_rx_charisk=4'hF and i_rx_data=32'hBCBCBCBC. /R/=8'h1C with K, /A/=8'h7C with K.
//  RESET_GT: wait i_gtpowergood=1, then o_gt_reset_all=1 for exactly RESET_HOLD clks, then ->WAIT_GT.
//  WAIT_GT: o_gt_reset_all=0; i_gt_reset_rx_done=1 -> CGS; GT_TIMEOUT clks elapsed -> RESET_GT.
//  CGS: comma enables=1, o_nsync=0. kcnt++ per /K/ word while i_rxbyteisaligned=1, else kcnt clears.
//   kcnt reaches CGS_K_CNT -> cgs_ok; o_nsync goes 1 on the first clk o_lmfc_pulse=1 at/after cgs_ok
//   (same clk as state->ILAS). Non-/K/ word before that clears kcnt and cgs_ok.
//  ILAS: comma enables=0, o_nsync=1. Wait first non-/K/ word: byte0 must be /R/, else ->CGS.
//   Count /A/ bytes (any lane position); 4th /A/ -> DATA on next clk. GT_TIMEOUT clks -> CGS.
//  DATA: o_data<=i_rx_data, o_data_valid<=1 (1-clk latency); first payload word = word after 4th /A/.
//   CGS_K_CNT consecutive /K/ words or i_rxbyteisaligned=0 -> CGS (o_nsync=0 next clk, valid=0).
//  Any state: i_gt_reset_rx_done falling (after WAIT_GT) or i_gtpowergood=0 -> RESET_GT; these take
//   priority over all other transitions on the same clk.
//  Outside DATA: o_data_valid=0, o_data holds last value. o_link_up=(state==DATA).
//  LMFC: counter 0..LMFC_PERIOD-1, wraps. SYSREF rising edge (reg'd compare) -> counter=0 next clk;
//   edge on clk where counter already would be 0 causes no phase change. Pulse when counter==0.
//   SYSREF never alters FSM state; LMFC runs in every state after reset.
// TESTING
//  1 powergood=1 at clk10 -> o_gt_reset_all high clks 11..26 (16), state 1; rx_done=1 -> state 2, nsync=0.
//  2 F=1,K=32 (period 8), sysref edge at clk100 -> o_lmfc_pulse at 101,109,117; edge at 104 -> 105,113.
//  3 CGS: 4 /K/ words w/ aligned=1 -> nsync rises on next lmfc_pulse; 3 /K/ + 1 data word -> nsync stays 0.
//  4 ILAS: /R/ word then 4 multiframes each ending 0x7C K -> state 4; first payload 0x12345678 on
//   o_data with valid=1 one clk later; ILAS starting 8'h55 -> back to CGS, nsync=0.
//  5 DATA: drop i_rxbyteisaligned one clk -> state 2, nsync=0, valid=0 next clk; 4 /K/ words -> same.
//  6 Assert i_rst_n=0 mid-DATA (async, between edges) -> all outputs 0 immediately, state 0.

Source files
------------

// File: rtl/jesd204b_rx_link_fsm.sv
// JESD204B subclass-1 receive link controller for a single lane.
// Sequences the GT wizard reset, runs code-group sync and ILAS detection,
// drives SYNC~ aligned to the local multiframe clock and gates user data.
//
// Outputs: o_state exposes the FSM state (0 RESET_GT, 1 WAIT_GT, 2 CGS,
// 3 ILAS, 4 DATA). The GT side has no flow control. o_data is meaningful
// only on clocks where o_data_valid is high, and the consumer must accept
// every such word.
`timescale 1ns/1ps

module jesd204b_rx_link_fsm #(
    parameter int USERDATA_WIDTH = 32,
    parameter int FRAME_SIZE     = 1,
    parameter int FMLC_NUM       = 32,
    parameter int LMFC_CNT_WIDTH = 8,
    parameter int RESET_HOLD     = 16,
    parameter int GT_TIMEOUT     = 65535,
    parameter int CGS_K_CNT      = 4
) (
    input  logic                        i_dclk,
    input  logic                        i_rst_n,
    input  logic                        i_sysref,
    input  logic                        i_gtpowergood,
    input  logic                        i_gt_reset_rx_done,
    input  logic                        i_rxbyteisaligned,
    input  logic [USERDATA_WIDTH-1:0]   i_rx_data,
    input  logic [USERDATA_WIDTH/8-1:0] i_rx_charisk,
    output logic                        o_gt_reset_all,
    output logic                        o_rxpcommaalignen,
    output logic                        o_rxmcommaalignen,
    output logic                        o_nsync,
    output logic                        o_lmfc_pulse,
    output logic [USERDATA_WIDTH-1:0]   o_data,
    output logic                        o_data_valid,
    output logic                        o_link_up,
    output logic [2:0]                  o_state
);

    localparam int NBYTES      = USERDATA_WIDTH / 8;
    localparam int LMFC_PERIOD = FRAME_SIZE * FMLC_NUM / 4;
    localparam int HOLD_W      = $clog2(RESET_HOLD + 1);
    localparam int TMR_W       = $clog2(GT_TIMEOUT + 1);
    localparam int KCNT_W      = $clog2(CGS_K_CNT + 1);

    localparam logic [LMFC_CNT_WIDTH-1:0] LMFC_LAST = LMFC_CNT_WIDTH'(LMFC_PERIOD - 1);
    localparam logic [HOLD_W-1:0]         HOLD_LAST = HOLD_W'(RESET_HOLD);
    localparam logic [TMR_W-1:0]          TMR_LAST  = TMR_W'(GT_TIMEOUT - 1);
    localparam logic [KCNT_W-1:0]         KCNT_LAST = KCNT_W'(CGS_K_CNT - 1);
    localparam logic [KCNT_W-1:0]         KCNT_MAX  = KCNT_W'(CGS_K_CNT);

    typedef enum logic [2:0] {
        ST_RESET_GT = 3'd0,
        ST_WAIT_GT  = 3'd1,
        ST_CGS      = 3'd2,
        ST_ILAS     = 3'd3,
        ST_DATA     = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [HOLD_W-1:0]           r_hold_cnt;
    logic [TMR_W-1:0]            r_timer;
    logic [KCNT_W-1:0]           r_kcnt;
    logic                        r_cgs_ok;
    logic                        r_ilas_started;
    logic [2:0]                  r_acnt;
    logic                        r_rx_done_d;
    logic                        r_sysref_d;
    logic [LMFC_CNT_WIDTH-1:0]   r_lmfc_cnt;
    logic                        r_lmfc_pulse;
    logic [USERDATA_WIDTH-1:0]   r_data;
    logic                        r_data_valid;

    logic                        w_is_k;
    logic                        w_k_aligned;
    logic                        w_byte0_is_r;
    logic [2:0]                  w_a_in_word;
    logic [3:0]                  w_a_total;
    logic                        w_a_done;
    logic                        w_sysref_edge;
    logic [LMFC_CNT_WIDTH-1:0]   w_lmfc_next;
    logic                        w_lmfc_zero_next;
    logic                        w_rx_done_fall;
    logic                        w_timeout;
    logic                        w_cgs_ok_now;
    logic                        w_state_change;

    // Word classification: full /K/ idle word, /R/ in byte0, and /A/ count.
    assign w_is_k       = (i_rx_charisk == '1) && (i_rx_data == {NBYTES{8'hBC}});
    assign w_k_aligned  = w_is_k && i_rxbyteisaligned;
    assign w_byte0_is_r = i_rx_charisk[0] && (i_rx_data[7:0] == 8'h1C);

    // Count /A/ characters in any byte lane of the current word.
    always_comb begin
        w_a_in_word = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (i_rx_charisk[b] && (i_rx_data[8*b +: 8] == 8'h7C)) begin
                w_a_in_word = w_a_in_word + 3'd1;
            end
        end
    end

    assign w_a_total      = {1'b0, r_acnt} + {1'b0, w_a_in_word};
    assign w_a_done       = (w_a_total >= 4'd4);
    assign w_sysref_edge  = i_sysref & ~r_sysref_d;
    assign w_rx_done_fall = r_rx_done_d & ~i_gt_reset_rx_done;
    assign w_timeout      = (r_timer == TMR_LAST);
    // CGS is satisfied on this clock if the threshold was already met or is met by this word;
    // any non-/K/ word withdraws it.
    assign w_cgs_ok_now   = w_is_k && (r_cgs_ok || (i_rxbyteisaligned && (r_kcnt >= KCNT_LAST)));
    assign w_state_change = (w_state_next != r_state);

    // LMFC next value: SYSREF edge forces phase zero, otherwise free-running wrap.
    always_comb begin
        w_lmfc_next = r_lmfc_cnt + 1'b1;
        if (w_sysref_edge || (r_lmfc_cnt == LMFC_LAST)) begin
            w_lmfc_next = '0;
        end
    end

    assign w_lmfc_zero_next = (w_lmfc_next == '0);

    // Next-state logic; GT power/reset loss overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET_GT: begin
                if (i_gtpowergood && (r_hold_cnt == HOLD_LAST)) w_state_next = ST_WAIT_GT;
            end
            ST_WAIT_GT: begin
                if (i_gt_reset_rx_done) w_state_next = ST_CGS;
                else if (w_timeout)     w_state_next = ST_RESET_GT;
            end
            ST_CGS: begin
                // SYNC~ release is timed so it coincides with the LMFC pulse.
                if (w_cgs_ok_now && w_lmfc_zero_next) w_state_next = ST_ILAS;
            end
            ST_ILAS: begin
                if (w_timeout) begin
                    w_state_next = ST_CGS;
                end else if (!r_ilas_started) begin
                    if (!w_is_k) begin
                        if (!w_byte0_is_r) w_state_next = ST_CGS;
                        else if (w_a_done) w_state_next = ST_DATA;
                    end
                end else if (w_a_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!i_rxbyteisaligned || (w_k_aligned && (r_kcnt >= KCNT_LAST))) begin
                    w_state_next = ST_CGS;
                end
            end
            default: w_state_next = ST_RESET_GT;
        endcase
        if (!i_gtpowergood ||
            (w_rx_done_fall && ((r_state == ST_CGS) || (r_state == ST_ILAS) || (r_state == ST_DATA)))) begin
            w_state_next = ST_RESET_GT;
        end
    end

    // State register plus the per-state counters; counters restart on every state change.
    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_RESET_GT;
            r_hold_cnt     <= '0;
            r_timer        <= '0;
            r_kcnt         <= '0;
            r_cgs_ok       <= 1'b0;
            r_ilas_started <= 1'b0;
            r_acnt         <= '0;
            r_rx_done_d    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rx_done_d <= i_gt_reset_rx_done;

            if ((r_state == ST_RESET_GT) && (w_state_next == ST_RESET_GT) && i_gtpowergood) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_state_change || !((r_state == ST_WAIT_GT) || (r_state == ST_ILAS))) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_state_change) begin
                r_kcnt         <= '0;
                r_cgs_ok       <= 1'b0;
                r_ilas_started <= 1'b0;
                r_acnt         <= '0;
            end else begin
                if (w_k_aligned) begin
                    if (r_kcnt != KCNT_MAX) r_kcnt <= r_kcnt + 1'b1;
                end else begin
                    r_kcnt <= '0;
                end
                r_cgs_ok <= (r_state == ST_CGS) && w_cgs_ok_now;
                if ((r_state == ST_ILAS) && (r_ilas_started || (!w_is_k && w_byte0_is_r))) begin
                    r_ilas_started <= 1'b1;
                    r_acnt         <= w_a_total[2:0];
                end
            end
        end
    end

    // LMFC counter and pulse run in every state; SYSREF only moves the phase.
    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sysref_d   <= 1'b0;
            r_lmfc_cnt   <= '0;
            r_lmfc_pulse <= 1'b0;
        end else begin
            r_sysref_d   <= i_sysref;
            r_lmfc_cnt   <= w_lmfc_next;
            r_lmfc_pulse <= w_lmfc_zero_next;
        end
    end

    // Capture payload only while remaining in DATA; the exit word is dropped.
    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else if ((r_state == ST_DATA) && (w_state_next == ST_DATA)) begin
            r_data       <= i_rx_data;
            r_data_valid <= 1'b1;
        end else begin
            r_data_valid <= 1'b0;
        end
    end

    assign o_gt_reset_all    = (r_state == ST_RESET_GT) && (r_hold_cnt != '0);
    assign o_rxpcommaalignen = (r_state == ST_CGS);
    assign o_rxmcommaalignen = (r_state == ST_CGS);
    assign o_nsync           = (r_state == ST_ILAS) || (r_state == ST_DATA);
    assign o_lmfc_pulse      = r_lmfc_pulse;
    assign o_data            = r_data;
    assign o_data_valid      = r_data_valid;
    assign o_link_up         = (r_state == ST_DATA);
    assign o_state           = r_state;

endmodule
